// File: rtl/memx_ctrl_pkg.sv
// Shared types, requester indices and sizing helpers for the x-vector
// memory access controller.
package memx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam int REQ_LOADER  = 0;
    localparam int REQ_XUPDATE = 1;

    function automatic int calc_dw(input int units, input int width);
        return units * width;
    endfunction

    function automatic int calc_aw(input int height);
        return $clog2(height) + 1;
    endfunction

endpackage

// File: rtl/memx_access_controller_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last time wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~last_q : req[1];
        last_d    = last_q;
        if (advance) begin
            last_d = gnt_idx;
        end
    end

    // Starting at 1 lets requester 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/memx_access_controller.sv
// Burst-level arbiter/sequencer sharing the x-vector memory between the
// loader and the x-update datapath, one burst at a time.
module memx_access_controller
    import memx_ctrl_pkg::*;
#(
    parameter int  no_of_units   = 8,
    parameter int  element_width = 32,
    parameter int  memory_height = 1000,
    parameter int  address_width = calc_aw(memory_height),
    localparam int DW            = calc_dw(no_of_units, element_width)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_write,
    input  logic [address_width-1:0] req_base_addr_0,
    input  logic [address_width-1:0] req_base_addr_1,
    input  logic [address_width-1:0] req_len_0,
    input  logic [address_width-1:0] req_len_1,
    output logic [1:0]               req_ready,
    input  logic [DW-1:0]            wr_data_0,
    input  logic [DW-1:0]            wr_data_1,
    input  logic [1:0]               wr_valid,
    output logic [1:0]               wr_ready,
    output logic [DW-1:0]            rd_data,
    output logic [1:0]               rd_valid,
    output logic                     rd_last,
    output logic [1:0]               done,
    output logic                     addr_err,
    output logic [address_width-1:0] mem_read_address,
    output logic [address_width-1:0] mem_write_address,
    output logic                     mem_write_enable,
    output logic [DW-1:0]            mem_write_data,
    input  logic [DW-1:0]            mem_output
);

    localparam logic [address_width-1:0] MAX_ADDR = address_width'(memory_height);
    localparam logic [address_width-1:0] ONE      = address_width'(1);

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    state_t                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic [address_width-1:0] cur_addr_q, cur_addr_d;
    logic [address_width-1:0] remaining_q, remaining_d;
    logic [DW-1:0]            rd_data_q, rd_data_d;
    logic [1:0]               rd_valid_q, rd_valid_d;
    logic                     rd_last_q, rd_last_d;
    logic [1:0]               done_q, done_d;
    logic                     addr_err_q, addr_err_d;

    logic                     gnt_valid;
    logic                     gnt_idx;
    logic                     gnt_take;
    logic [address_width-1:0] gnt_len;
    logic                     beat;
    logic                     beat_oob;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (gnt_take),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_len  = gnt_idx ? req_len_1 : req_len_0;
    assign beat_oob = (cur_addr_q > MAX_ADDR);

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        cur_addr_d       = cur_addr_q;
        remaining_d      = remaining_q;
        rd_data_d        = rd_data_q;
        rd_valid_d       = '0;
        rd_last_d        = 1'b0;
        done_d           = '0;
        addr_err_d       = 1'b0;
        req_ready        = '0;
        wr_ready         = '0;
        mem_write_enable = 1'b0;
        gnt_take         = 1'b0;
        beat             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    gnt_take    = 1'b1;
                    req_ready   = onehot2(gnt_idx);
                    owner_d     = gnt_idx;
                    cur_addr_d  = gnt_idx ? req_base_addr_1 : req_base_addr_0;
                    remaining_d = gnt_len;
                    if (gnt_len == '0) begin
                        done_d = onehot2(gnt_idx);
                    end else if (req_write[gnt_idx]) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                beat       = 1'b1;
                rd_data_d  = mem_output;
                rd_valid_d = onehot2(owner_q);
                rd_last_d  = (remaining_q == ONE);
            end
            ST_WRITE: begin
                wr_ready         = onehot2(owner_q);
                beat             = wr_valid[owner_q];
                mem_write_enable = beat && !beat_oob;
            end
            default: state_d = ST_IDLE;
        endcase

        // Out-of-range beats still consume a slot so burst length is honoured.
        if (beat) begin
            addr_err_d  = beat_oob;
            cur_addr_d  = cur_addr_q + ONE;
            remaining_d = remaining_q - ONE;
            if (remaining_q == ONE) begin
                state_d = ST_IDLE;
                done_d  = onehot2(owner_q);
            end
        end

        if (reset) begin
            req_ready        = '0;
            wr_ready         = '0;
            mem_write_enable = 1'b0;
            gnt_take         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            rd_last_q   <= 1'b0;
            done_q      <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign rd_data           = rd_data_q;
    assign rd_valid          = rd_valid_q;
    assign rd_last           = rd_last_q;
    assign done              = done_q;
    assign addr_err          = addr_err_q;
    assign mem_read_address  = cur_addr_q;
    assign mem_write_address = cur_addr_q;
    assign mem_write_data    = (owner_q == 1'(REQ_XUPDATE)) ? wr_data_1 : wr_data_0;

endmodule

// File: doc/memx_access_controller.md
Name: memx_access_controller

Overview:
Burst-level arbiter and sequencer that shares the single-port-write / async-read x-vector memory between two requesters. Typical requesters are the host/loader (requester 0) and the x-update datapath (requester 1). Each requester asks for a read or write burst over a contiguous address range. The controller grants one burst at a time with round-robin fairness, drives the memory address/write signals beat by beat, and returns read data with a fixed 1-cycle latency.

Parameters:
no_of_units, 8, vector lanes per memory word
element_width, 32, bits per lane
memory_height, 1000, highest valid word address (valid range 0..memory_height inclusive)
address_width, $clog2(memory_height)+1, address and burst-length width
DW (localparam), no_of_units*element_width, memory word width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  2  per-requester burst request; held until req_ready
req_write  in  2  1 = write burst, 0 = read burst
req_base_addr_0 / req_base_addr_1  in  address_width  burst start address
req_len_0 / req_len_1  in  address_width  beat count
req_ready  out  2  one-cycle pulse when the burst is accepted
wr_data_0 / wr_data_1  in  DW  write beat data
wr_valid  in  2  write beat present
wr_ready  out  2  controller accepts a write beat from this requester
rd_data  out  DW  registered read beat
rd_valid  out  2  one-hot owner of rd_data this cycle
rd_last  out  1  final read beat of the burst
done  out  2  one-cycle pulse at burst completion
addr_err  out  1  one-cycle pulse: beat address > memory_height
mem_read_address  out  address_width  to memory read address
mem_write_address  out  address_width  to memory write address
mem_write_enable  out  1  to memory write enable
mem_write_data  out  DW  to memory write data
mem_output  in  DW  from memory (combinational read)

Behaviour:
- Reset: state=IDLE, last_grant=1 (so requester 0 wins first tie), req_ready/wr_ready/rd_valid/done=0, rd_last=0, addr_err=0, mem_write_enable=0, addresses=0, rd_data=0. Reset mid-burst abandons the burst silently with no done pulse. A write in the reset cycle is suppressed.
- States: IDLE, READ, WRITE.
- IDLE:
  - Single req_valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - On grant: pulse req_ready[g], latch g, base address, len and direction; cur_addr=base, remaining=len; last_grant=g.
  - len=0: no memory access; pulse done[g] in the cycle after the grant and stay IDLE.
  - Otherwise go to READ or WRITE. The grant cycle costs one cycle.
- READ:
  - mem_read_address=cur_addr (registered).
  - Every cycle: rd_data<=mem_output, rd_valid<=onehot(g), rd_last<=(remaining==1).
  - cur_addr++, remaining-- each cycle. One beat per cycle, no backpressure.
  - Data appears 1 cycle after its address. After the last address, return to IDLE. done[g] pulses together with the rd_last beat.
- WRITE:
  - wr_ready[g]=1 (combinational from state); the other requester's wr_ready=0.
  - A beat commits when wr_valid[g]=1: mem_write_enable=1, mem_write_address=cur_addr, mem_write_data=wr_data_g, all combinational, so it is written on the same edge. cur_addr++, remaining--.
  - wr_valid low stalls the burst indefinitely.
  - After the last beat, go to IDLE; done[g] pulses the next cycle.
  - wr_valid from the non-granted requester is ignored.
- Address bounds: a beat with cur_addr > memory_height still counts and advances, but mem_write_enable is forced 0 and addr_err pulses. Read beats still return (undefined data) and pulse addr_err.
- cur_addr wraps modulo 2^address_width.
- Arbitration happens only in IDLE. A request arriving during a burst waits. The next grant can occur in the cycle after the return to IDLE.
- Changing req_* while req_valid is high before req_ready is a protocol violation; the values are sampled at grant.

Decomposition:
- Shared package memx_ctrl_pkg holds:
  - state enum (IDLE/READ/WRITE)
  - requester index constants (REQ_LOADER=0, REQ_XUPDATE=1)
  - DW/address_width derivation helpers
- Optional sub-module rr_arbiter2 (2-way round-robin, last_grant register). Everything else stays inline.

Test Plan:
- Reset, then req0 write base=5 len=3, wr_valid held: req_ready[0] pulses; mem_write_enable high 3 consecutive cycles at addresses 5,6,7 with the given data; done[0] pulses once.
- Read back req1 base=5 len=3: rd_valid=2'b10 for 3 cycles, data equals the written words, rd_last on the 3rd beat; first beat 1 cycle after mem_read_address=5.
- Both req_valid asserted in the same cycle after reset, twice in a row: grants alternate 0,1,0,1; the loser waits with req_valid held and no lost request.
- Write len=4 with wr_valid deasserted for 2 cycles after beat 2: exactly 4 writes at consecutive addresses, no write during the stall, wr_ready[1] stays 0 throughout.
- Write base=999 len=3 (memory_height=1000): writes at 999 and 1000; the third beat (address 1001) is suppressed and addr_err pulses once; done still pulses.
- len=0 request gives req_ready then done with no mem_write_enable. Reset asserted mid-WRITE returns to IDLE, no done pulse, all outputs at reset values.
